// File: rtl/adr_seq.sv
// Address sequencer: sweeps NS steps per pass, choosing between two
// auto-incrementing address pointers (An / Mn) from a per-step select mask.
module adr_seq #(
  parameter int ST_W = 3,
  parameter int AW = 8,
  parameter logic [(1 << ST_W)-1:0] SEL_INIT = {((1 << ST_W) / 4){4'b0001}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    mask_we,
  input  logic [(1 << ST_W)-1:0]  mask_din,
  input  logic [AW-1:0]           base_a,
  input  logic [AW-1:0]           base_m,
  input  logic [AW-1:0]           len,
  output logic [ST_W-1:0]         st,
  output logic                    adr,
  output logic [AW-1:0]           addr,
  output logic                    busy,
  output logic                    done
);

  localparam int NS = 1 << ST_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [NS-1:0]   mask;
  logic [ST_W-1:0] st_q;
  logic [AW-1:0]   a_ptr;
  logic [AW-1:0]   m_ptr;
  logic [AW-1:0]   sweep;
  logic [AW-1:0]   len_q;
  logic            busy_q;
  logic            done_q;
  logic            sel;
  logic            in_run;

  // Step outputs are decoded from registered state so they are valid for the
  // whole cycle and collapse to zero outside RUN.
  assign in_run = (state == RUN);
  assign sel    = in_run ? mask[st_q] : 1'b0;
  assign adr    = sel;
  assign addr   = in_run ? (sel ? m_ptr : a_ptr) : '0;
  assign st     = in_run ? st_q : '0;
  assign busy   = busy_q;
  assign done   = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mask   <= SEL_INIT;
      st_q   <= '0;
      a_ptr  <= '0;
      m_ptr  <= '0;
      sweep  <= '0;
      len_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // A mask write on the start edge is visible to the run it launches.
          if (mask_we) mask <= mask_din;
          if (start) begin
            a_ptr <= base_a;
            m_ptr <= base_m;
            st_q  <= '0;
            sweep <= '0;
            len_q <= len;
            if (len == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= RUN;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            if (sel) m_ptr <= m_ptr + AW'(1);
            else     a_ptr <= a_ptr + AW'(1);
            st_q <= st_q + ST_W'(1);
            if (&st_q) begin
              if (sweep == len_q - AW'(1)) begin
                state  <= DONE;
                st_q   <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                sweep <= sweep + AW'(1);
              end
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adr_seq.sv
// Bench for adr_seq: each run is predicted as a list of per-step outputs built
// from the base addresses, sweep count and select mask, then replayed cycle by cycle.
module tb_adr_seq;

  localparam int ST_W = 3;
  localparam int AW   = 8;
  localparam int NS   = 1 << ST_W;
  localparam int EW   = ST_W + 1 + AW + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            stall;
  logic            mask_we;
  logic [NS-1:0]   mask_din;
  logic [AW-1:0]   base_a;
  logic [AW-1:0]   base_m;
  logic [AW-1:0]   len;
  logic [ST_W-1:0] st;
  logic            adr;
  logic [AW-1:0]   addr;
  logic            busy;
  logic            done;

  adr_seq #(.ST_W(ST_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .mask_we(mask_we), .mask_din(mask_din),
    .base_a(base_a), .base_m(base_m), .len(len),
    .st(st), .adr(adr), .addr(addr), .busy(busy), .done(done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: one entry per expected visible cycle, {st, adr, addr, busy, done}
  int n_cmp  = 0;
  int n_fail = 0;
  logic [NS-1:0] ref_mask;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] pack(input logic [ST_W-1:0] s, input logic a,
                                         input logic [AW-1:0] ad, input logic b,
                                         input logic d);
    return {s, a, ad, b, d};
  endfunction

  task automatic check(input string tag, input logic [EW-1:0] expv);
    logic [EW-1:0] obs;
    obs = {st, adr, addr, busy, done};
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed st=%0d adr=%0b addr=%02h busy=%0b done=%0b, expected st=%0d adr=%0b addr=%02h busy=%0b done=%0b",
             tag, obs[13:11], obs[10], obs[9:2], obs[1], obs[0],
             expv[13:11], expv[10], expv[9:2], expv[1], expv[0]);
    end
  endtask

  // Reference: each step picks An or Mn from the mask; the chosen pointer
  // then advances. A run is len full sweeps followed by one done cycle.
  function automatic void build_model(input logic [AW-1:0] a, input logic [AW-1:0] m,
                                      input logic [AW-1:0] l, input logic [NS-1:0] msk);
    logic use_m;
    exp_q.delete();
    for (int sw = 0; sw < int'(l); sw++) begin
      for (int s = 0; s < NS; s++) begin
        use_m = msk[s];
        exp_q.push_back(pack(ST_W'(s), use_m, use_m ? m : a, 1'b1, 1'b0));
        if (use_m) m = m + 8'd1;
        else       a = a + 8'd1;
      end
    end
    exp_q.push_back(pack('0, 1'b0, '0, 1'b0, 1'b1));
  endfunction

  // driver tasks
  task automatic write_mask(input logic [NS-1:0] m);
    mask_we  = 1'b1;
    mask_din = m;
    @(negedge clk);
    mask_we  = 1'b0;
    ref_mask = m;
    check("mask_write_idle", '0);
  endtask

  // stall_mode: 0 none, 1 stall on RUN cycles 3-4, 2 random.
  // abort_at >= 0 pulses rst during that checked cycle.
  task automatic run_seq(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] m,
                         input logic [AW-1:0] l, input logic wr, input logic [NS-1:0] wmask,
                         input int stall_mode, input logic noise, input int abort_at);
    logic [EW-1:0] e;
    int cyc;
    check({tag, "_idle"}, '0);
    if (wr) ref_mask = wmask;
    build_model(a, m, l, ref_mask);
    base_a   = a;
    base_m   = m;
    len      = l;
    start    = 1'b1;
    mask_we  = wr;
    mask_din = wmask;
    @(negedge clk);
    start    = 1'b0;
    mask_we  = 1'b0;
    base_a   = AW'($urandom);
    base_m   = AW'($urandom);
    len      = AW'($urandom);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      e = exp_q[0];
      check(tag, e);
      if (abort_at >= 0 && cyc == abort_at) begin
        rst = 1'b1;
        #1;
        check({tag, "_rst_async"}, '0);
        exp_q.delete();
        ref_mask = 8'h11;
        break;
      end
      stall = 1'b0;
      if (e[1]) begin
        case (stall_mode)
          1:       stall = (cyc == 2 || cyc == 3);
          2:       stall = ($urandom_range(0, 3) == 0);
          default: stall = 1'b0;
        endcase
        if (!stall) void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        mask_we  = 1'($urandom_range(0, 1));
        mask_din = NS'($urandom);
      end
      cyc++;
      @(negedge clk);
    end
    stall   = 1'b0;
    start   = 1'b0;
    mask_we = 1'b0;
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed %0d entries left, expected 0", tag, exp_q.size());
    end
    check({tag, "_after"}, '0);
  endtask

  // directed and random steps
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    stall    = 1'b0;
    mask_we  = 1'b0;
    mask_din = '0;
    base_a   = '0;
    base_m   = '0;
    len      = '0;
    ref_mask = 8'h11;
    repeat (2) @(negedge clk);
    check("reset", '0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", '0);

    run_seq("seq_default", 8'h10, 8'h80, 8'd1, 1'b0, '0, 0, 1'b0, -1);
    run_seq("seq_stall", 8'h10, 8'h80, 8'd1, 1'b0, '0, 1, 1'b0, -1);
    run_seq("seq_ignore_we", 8'h10, 8'h80, 8'd1, 1'b0, '0, 0, 1'b1, -1);
    write_mask(8'hFF);
    run_seq("seq_all_m", 8'h10, 8'h80, 8'd2, 1'b0, '0, 0, 1'b0, -1);
    run_seq("seq_len0", 8'h10, 8'h80, 8'd0, 1'b0, '0, 0, 1'b0, -1);
    write_mask(8'h00);
    run_seq("seq_wrap", 8'hFE, 8'h80, 8'd1, 1'b0, '0, 0, 1'b0, -1);
    run_seq("seq_start_we", 8'h20, 8'hF0, 8'd1, 1'b1, 8'hA5, 0, 1'b0, -1);

    write_mask(8'h11);
    run_seq("seq_abort", 8'h10, 8'h80, 8'd1, 1'b0, '0, 0, 1'b0, 3);
    @(negedge clk);
    check("abort_held", '0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle_no_done", '0);
    end
    run_seq("seq_after_abort", 8'h10, 8'h80, 8'd1, 1'b0, '0, 0, 1'b0, -1);

    for (int i = 0; i < 8; i++) begin
      run_seq("seq_random", AW'($urandom), AW'($urandom), AW'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), NS'($urandom), 2, 1'b1, -1);
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
